bin2bcd_seq: RTL and testbench

- Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
- Sits between the 4x4 multiplier's 8-bit product and the per-digit seven-segment decoders.
- Lets the product appear on the displays in decimal (000-225) instead of hex.
- Converts one operand per start request and holds the BCD result until the next conversion completes.

---
 rtl/bin2bcd_pkg.sv | 7 +
 rtl/bcd_add3_cell.sv | 9 +
 rtl/bin2bcd_seq.sv | 96 +++++++++
 tb/tb_bin2bcd_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared states and constants for the double-dabble converter
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;
  localparam int ADD3_VAL    = 3;
endpackage

// File: rtl/bcd_add3_cell.sv
// bcd_add3_cell: per-digit add-3 correction applied before each double-dabble shift
module bcd_add3_cell
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] in_i,
  output logic [BCD_DIGIT_W-1:0] out_o
);
  assign out_o = (in_i >= BCD_DIGIT_W'(ADD3_THRESH)) ? in_i + BCD_DIGIT_W'(ADD3_VAL) : in_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter; BIN2BCD_BLANK_EN adds leading-zero blank flags
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]             blank
);
  localparam int SW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  if (10**DIGITS <= 2**WIDTH - 1) begin : g_bad_params
    $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
  end
  state_e         state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [SW-1:0]  scratch_q, scratch_d, adj;
  logic [CW-1:0]  count_q, count_d;
  logic [SW-1:0]  bcd_q, bcd_d;
  logic           load;
  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .in_i  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .out_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end
  assign load = (state_q == SHIFT) && (count_q == CW'(WIDTH - 1));
  // next-state: accept in IDLE/DONE, correct-then-shift in SHIFT, publish on the final shift
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    bcd_d     = bcd_q;
    if (state_q != SHIFT && start) begin
      state_d   = SHIFT;
      shift_d   = bin;
      scratch_d = '0;
      count_d   = '0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == SHIFT) begin
      {scratch_d, shift_d} = {adj[SW-2:0], shift_q, 1'b0};
      count_d = count_q + CW'(1);
      state_d = load ? DONE : SHIFT;
      bcd_d   = load ? scratch_d : bcd_q;
    end
  end
  // state and datapath registers, cleared asynchronously so an abort leaves bcd at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      bcd_q     <= bcd_d;
    end
  end
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_run;
  // digit i blanks when it and every higher digit are zero; digit 0 always shows
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (bcd_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_d[i] = zero_run;
    end
  end
  // blank flags track bcd, changing only when a result is published
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= '0;
    else        blank_q <= load ? blank_d : blank_q;
  end
  assign blank = blank_q;
`else
  assign blank = '0;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq with directed vectors
module tb_bin2bcd_seq;
  logic        clk, rst_n, start, busy, done;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [2:0]  blank;
  int          n_cmp = 0, n_fail = 0;
  logic [14:0] exp_q[$];
  logic [14:0] mon_e;

  bin2bcd_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] bl(input logic [2:0] b);
`ifdef BIN2BCD_BLANK_EN
    return b;
`else
    return 3'b000;
`endif
  endfunction

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("bcd", {20'd0, bcd}, {20'd0, mon_e[14:3]});
        chk("blank", {29'd0, blank}, {29'd0, mon_e[2:0]});
      end
    end
  end

  task automatic issue(input logic [7:0] b, input logic [11:0] e, input logic [2:0] bk, input bit push);
    @(negedge clk);
    bin = b;
    start = 1'b1;
    if (push) exp_q.push_back({e, bl(bk)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lat);
    int c = 0, nb = 0;
    while (!done && c < 20) begin
      if (busy) nb++;
      @(negedge clk);
      c++;
    end
    chk({nm, "_latency"}, c, lat);
    chk({nm, "_busy_cycles"}, nb, lat);
  endtask

  logic [7:0]  v_bin[5] = '{8'd0, 8'd225, 8'd255, 8'd9, 8'd10};
  logic [11:0] v_bcd[5] = '{12'h000, 12'h225, 12'h255, 12'h009, 12'h010};
  logic [2:0]  v_bl[5]  = '{3'b110, 3'b000, 3'b000, 3'b110, 3'b100};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bcd", bcd, 0);
    chk("reset_blank", blank, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      issue(v_bin[i], v_bcd[i], v_bl[i], 1'b1);
      wait_done($sformatf("vec%0d", i), 8);
    end
    issue(8'd7, 12'h007, 3'b110, 1'b1);
    wait_done("blank7", 8);
    issue(8'd105, 12'h105, 3'b000, 1'b1);
    wait_done("blank105", 8);
    // start pulsed mid-SHIFT must be ignored
    issue(8'd99, 12'h099, 3'b100, 1'b1);
    repeat (3) @(negedge clk);
    bin = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("midshift", 4);
    repeat (12) @(negedge clk);
    chk("midshift_no_restart", busy, 0);
    // start held through DONE gives a back-to-back conversion
    @(negedge clk);
    bin = 8'd7;
    start = 1'b1;
    exp_q.push_back({12'h007, bl(3'b110)});
    exp_q.push_back({12'h042, bl(3'b100)});
    @(negedge clk);
    bin = 8'd42;
    wait_done("b2b_first", 8);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_restart_busy", busy, 1);
    begin
      int c = 0;
      while (!done && c < 20) begin
        chk("b2b_hold_bcd", bcd, 12'h007);
        @(negedge clk);
        c++;
      end
      chk("b2b_second_latency", c, 8);
    end
    // asynchronous reset during the 4th SHIFT cycle aborts the conversion
    issue(8'd128, 12'h128, 3'b000, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_blank", blank, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle", busy, 0);
    issue(8'd128, 12'h128, 3'b000, 1'b1);
    wait_done("after_abort", 8);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
